// File: rtl/noise_gate_pkg.sv
// Shared definitions for the noise gate: state encodings and gain scaling helpers.
package noise_gate_pkg;

   localparam int STATE_WIDTH = 3;

   typedef enum logic [STATE_WIDTH-1:0] {
      ST_CLOSED  = 3'd0,
      ST_ATTACK  = 3'd1,
      ST_OPEN    = 3'd2,
      ST_HOLD    = 3'd3,
      ST_RELEASE = 3'd4
   } gate_state_e;

   // Unity gain for a gain word with gw fraction bits.
   function automatic longint unsigned gain_one(input int gw);
      return longint'(1) << gw;
   endfunction

endpackage

// File: rtl/noise_gate_envelope_peak.sv
// Peak envelope follower: saturating magnitude, instant attack, shift-based decay.
module envelope_peak
   import noise_gate_pkg::*;
#(
   parameter int DIN_WIDTH = 32,
   parameter int ENV_SHIFT = 8
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        en,
   input  logic signed [DIN_WIDTH-1:0] din,
   output logic        [DIN_WIDTH-2:0] env_next
);

   localparam int EW = DIN_WIDTH - 1;

   logic          is_min;
   logic [EW-1:0] mag;
   logic [EW-1:0] env;

   // Magnitude with the most-negative code clamped to full scale, then peak/decay
   always_comb begin
      is_min = din[DIN_WIDTH-1] && (din[EW-1:0] == '0);
      if (is_min)
         mag = '1;
      else if (din[DIN_WIDTH-1])
         mag = ~din[EW-1:0] + EW'(1);
      else
         mag = din[EW-1:0];
      env_next = (mag > env) ? mag : env - (env >> ENV_SHIFT);
   end

   // Envelope only advances on accepted samples
   always_ff @(posedge clk) begin
      if (!rst_n)
         env <= '0;
      else if (en)
         env <= env_next;
   end

endmodule

// File: rtl/noise_gate.sv
// Envelope-driven noise gate with attack/hold/release gain ramp and one
// registered valid/ready stage. Define NOISE_GATE_HOLD_EN to include the
// HOLD state and its sample counter; otherwise OPEN falls straight to RELEASE.
//
// state   | meaning
// CLOSED  | gain parked at 0, waiting for envelope to reach open threshold
// ATTACK  | gain ramping up toward unity
// OPEN    | unity gain, watching for envelope below close threshold
// HOLD    | unity gain for a fixed number of samples before releasing
// RELEASE | gain ramping down toward 0
module noise_gate
   import noise_gate_pkg::*;
#(
   parameter int DIN_WIDTH    = 32,
   parameter int GAIN_WIDTH   = 16,
   parameter int OPEN_THRESH  = 2**12,
   parameter int CLOSE_THRESH = 2**11,
   parameter int ENV_SHIFT    = 8,
   parameter int HOLD_SAMPLES = 4800,
   parameter int ATTACK_STEP  = 2**8,
   parameter int RELEASE_STEP = 2**6
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic signed [DIN_WIDTH-1:0] din,
   input  logic                        din_tvalid,
   output logic                        din_tready,
   output logic signed [DIN_WIDTH-1:0] dout,
   output logic                        dout_tvalid,
   input  logic                        dout_tready,
   output logic [STATE_WIDTH-1:0]      gate_state
);

   localparam int EW  = DIN_WIDTH - 1;
   localparam int GW1 = GAIN_WIDTH + 1;
   localparam int GSW = GAIN_WIDTH + 2;
   localparam int PW  = DIN_WIDTH + GAIN_WIDTH + 1;

   localparam logic [GW1-1:0] GAIN_ONE   = GW1'(gain_one(GAIN_WIDTH));
   localparam logic [GW1-1:0] REL_STEP_G = GW1'(RELEASE_STEP);
   localparam logic [EW-1:0]  OPEN_T     = EW'(OPEN_THRESH);
   localparam logic [EW-1:0]  CLOSE_T    = EW'(CLOSE_THRESH);

   gate_state_e         state;
   logic [GW1-1:0]      gain;
   logic                accept;
   logic [EW-1:0]       env_next;
   logic                open_hit;
   logic                close_hit;
   logic [GSW-1:0]      gain_sum;
   logic                up_full;
   logic [GW1-1:0]      gain_up;
   logic [GW1-1:0]      gain_dn;
   logic                dn_zero;
   logic signed [PW-1:0] din_x;
   logic signed [PW-1:0] gain_x;
   logic signed [PW-1:0] prod;
   logic signed [PW-1:0] prod_sh;
   logic signed [DIN_WIDTH-1:0] scaled;
   logic                unused_prod;

`ifdef NOISE_GATE_HOLD_EN
   localparam int HCW = (HOLD_SAMPLES < 1) ? 1 : $clog2(HOLD_SAMPLES + 1);
   localparam logic [HCW-1:0] HOLD_LOAD = HCW'(HOLD_SAMPLES);
   logic [HCW-1:0] hold_cnt;
`else
   localparam int unused_hold_samples = HOLD_SAMPLES;
`endif

   assign din_tready = !dout_tvalid || dout_tready;
   assign accept     = din_tvalid && din_tready;
   assign gate_state = state;

   envelope_peak #(
      .DIN_WIDTH (DIN_WIDTH),
      .ENV_SHIFT (ENV_SHIFT)
   ) u_env (
      .clk      (clk),
      .rst_n    (rst_n),
      .en       (accept),
      .din      (din),
      .env_next (env_next)
   );

   // Threshold compares, saturating ramp steps and the gain multiply
   always_comb begin
      open_hit  = env_next >= OPEN_T;
      close_hit = env_next < CLOSE_T;
      gain_sum  = GSW'(gain) + GSW'(ATTACK_STEP);
      up_full   = gain_sum >= GSW'(GAIN_ONE);
      gain_up   = up_full ? GAIN_ONE : gain_sum[GW1-1:0];
      gain_dn   = (gain > REL_STEP_G) ? gain - REL_STEP_G : '0;
      dn_zero   = (gain_dn == '0);
      din_x     = PW'(din);
      gain_x    = PW'(gain);
      prod      = din_x * gain_x;
      prod_sh   = prod >>> GAIN_WIDTH;
      scaled    = prod_sh[DIN_WIDTH-1:0];
   end

   assign unused_prod = ^prod_sh[PW-1:DIN_WIDTH];

   // Gate state machine; gain moves on the sample that enters or stays in a ramp
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= ST_CLOSED;
         gain  <= '0;
`ifdef NOISE_GATE_HOLD_EN
         hold_cnt <= '0;
`endif
      end else if (accept) begin
         case (state)
            ST_CLOSED: begin
               if (open_hit) begin
                  gain  <= gain_up;
                  state <= up_full ? ST_OPEN : ST_ATTACK;
               end
            end
            ST_ATTACK: begin
               gain <= gain_up;
               if (up_full)
                  state <= ST_OPEN;
            end
            ST_OPEN: begin
               if (close_hit) begin
`ifdef NOISE_GATE_HOLD_EN
                  state    <= ST_HOLD;
                  hold_cnt <= HOLD_LOAD;
`else
                  gain  <= gain_dn;
                  state <= dn_zero ? ST_CLOSED : ST_RELEASE;
`endif
               end
            end
`ifdef NOISE_GATE_HOLD_EN
            ST_HOLD: begin
               if (open_hit) begin
                  state <= ST_OPEN;
               end else if (hold_cnt <= HCW'(1)) begin
                  hold_cnt <= '0;
                  gain     <= gain_dn;
                  state    <= dn_zero ? ST_CLOSED : ST_RELEASE;
               end else begin
                  hold_cnt <= hold_cnt - HCW'(1);
               end
            end
`endif
            ST_RELEASE: begin
               if (open_hit) begin
                  gain  <= gain_up;
                  state <= up_full ? ST_OPEN : ST_ATTACK;
               end else begin
                  gain  <= gain_dn;
                  if (dn_zero)
                     state <= ST_CLOSED;
               end
            end
            default: state <= ST_CLOSED;
         endcase
      end
   end

   // Output register: load on accept, drop valid once drained with nothing new
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         dout        <= '0;
         dout_tvalid <= 1'b0;
      end else if (accept) begin
         dout        <= scaled;
         dout_tvalid <= 1'b1;
      end else if (dout_tready) begin
         dout_tvalid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_noise_gate.sv
// Directed bench for noise_gate using small thresholds and coarse ramp steps.
module tb_noise_gate;

   logic               clk;
   logic               rst_n;
   logic signed [31:0] din;
   logic               din_tvalid;
   logic               din_tready;
   logic signed [31:0] dout;
   logic               dout_tvalid;
   logic               dout_tready;
   logic [2:0]         gate_state;

   int n_vec = 0;
   int n_err = 0;

   noise_gate #(
      .DIN_WIDTH    (32),
      .GAIN_WIDTH   (16),
      .OPEN_THRESH  (4096),
      .CLOSE_THRESH (2048),
      .ENV_SHIFT    (2),
      .HOLD_SAMPLES (4),
      .ATTACK_STEP  (16384),
      .RELEASE_STEP (8192)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .din         (din),
      .din_tvalid  (din_tvalid),
      .din_tready  (din_tready),
      .dout        (dout),
      .dout_tvalid (dout_tvalid),
      .dout_tready (dout_tready),
      .gate_state  (gate_state)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: time limit reached before summary");
      $fatal(1);
   end

   // Present one sample for a single edge (caller keeps dout_tready high)
   task automatic push(input logic signed [31:0] x);
      din        = x;
      din_tvalid = 1'b1;
      @(posedge clk);
      #1;
      din_tvalid = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      n_vec++; if (dout !== 32'sd0) begin n_err++; $display("FAIL reset_dout: got %0d want 0", dout); end
      n_vec++; if (dout_tvalid !== 1'b0) begin n_err++; $display("FAIL reset_tvalid: got %b want 0", dout_tvalid); end
      n_vec++; if (din_tready !== 1'b1) begin n_err++; $display("FAIL reset_tready: got %b want 1", din_tready); end
      n_vec++; if (gate_state !== 3'd0) begin n_err++; $display("FAIL reset_state: got %0d want 0", gate_state); end
      rst_n = 1'b1;
   endtask

   task automatic test_closed_low_level();
      for (int i = 0; i < 100; i++) begin
         push(32'sd1000);
         n_vec++; if (dout !== 32'sd0) begin n_err++; $display("FAIL closed_dout[%0d]: got %0d want 0", i, dout); end
         n_vec++; if (gate_state !== 3'd0) begin n_err++; $display("FAIL closed_state[%0d]: got %0d want 0", i, gate_state); end
      end
   endtask

   task automatic test_attack_step();
      logic signed [31:0] exp_d [7];
      logic [2:0]         exp_s [7];
      exp_d = '{32'sd0, 32'sd2500, 32'sd5000, 32'sd7500, 32'sd10000, 32'sd10000, 32'sd10000};
      exp_s = '{3'd1, 3'd1, 3'd1, 3'd2, 3'd2, 3'd2, 3'd2};
      for (int i = 0; i < 7; i++) begin
         push(32'sd10000);
         n_vec++; if (dout !== exp_d[i]) begin n_err++; $display("FAIL attack_dout[%0d]: got %0d want %0d", i, dout, exp_d[i]); end
         n_vec++; if (gate_state !== exp_s[i]) begin n_err++; $display("FAIL attack_state[%0d]: got %0d want %0d", i, gate_state, exp_s[i]); end
      end
   endtask

   task automatic test_release();
      int exp_s;
      for (int i = 1; i <= 20; i++) begin
         push(32'sd0);
`ifdef NOISE_GATE_HOLD_EN
         exp_s = (i <= 5) ? 2 : (i <= 9) ? 3 : (i <= 16) ? 4 : 0;
`else
         exp_s = (i <= 5) ? 2 : (i <= 12) ? 4 : 0;
`endif
         n_vec++; if (gate_state !== 3'(exp_s)) begin n_err++; $display("FAIL release_state[%0d]: got %0d want %0d", i, gate_state, exp_s); end
         n_vec++; if (dout !== 32'sd0) begin n_err++; $display("FAIL release_dout[%0d]: got %0d want 0", i, dout); end
      end
   endtask

   task automatic test_reattack_from_release();
      int n_zero;
`ifdef NOISE_GATE_HOLD_EN
      n_zero = 12;
`else
      n_zero = 8;
`endif
      for (int i = 0; i < 5; i++) push(32'sd10000);
      n_vec++; if (gate_state !== 3'd2) begin n_err++; $display("FAIL reattack_open: got %0d want 2", gate_state); end
      for (int i = 0; i < n_zero; i++) push(32'sd0);
      n_vec++; if (gate_state !== 3'd4) begin n_err++; $display("FAIL reattack_in_release: got %0d want 4", gate_state); end
      // gain is 40960 here; negative product floors toward -inf
      push(-32'sd10001);
      n_vec++; if (dout !== -32'sd6251) begin n_err++; $display("FAIL reattack_neg_dout: got %0d want -6251", dout); end
      n_vec++; if (gate_state !== 3'd1) begin n_err++; $display("FAIL reattack_state1: got %0d want 1", gate_state); end
      push(32'sd10000);
      n_vec++; if (dout !== 32'sd8750) begin n_err++; $display("FAIL reattack_dout2: got %0d want 8750", dout); end
      n_vec++; if (gate_state !== 3'd2) begin n_err++; $display("FAIL reattack_state2: got %0d want 2", gate_state); end
      push(32'sd10000);
      n_vec++; if (dout !== 32'sd10000) begin n_err++; $display("FAIL reattack_dout3: got %0d want 10000", dout); end
   endtask

   task automatic test_backpressure();
      dout_tready = 1'b0;
      din         = 32'sd5555;
      din_tvalid  = 1'b1;
      #1;
      n_vec++; if (din_tready !== 1'b0) begin n_err++; $display("FAIL bp_tready_now: got %b want 0", din_tready); end
      for (int i = 0; i < 5; i++) begin
         @(posedge clk);
         #1;
         n_vec++; if (din_tready !== 1'b0) begin n_err++; $display("FAIL bp_tready[%0d]: got %b want 0", i, din_tready); end
         n_vec++; if (dout !== 32'sd10000) begin n_err++; $display("FAIL bp_dout[%0d]: got %0d want 10000", i, dout); end
         n_vec++; if (dout_tvalid !== 1'b1) begin n_err++; $display("FAIL bp_tvalid[%0d]: got %b want 1", i, dout_tvalid); end
         n_vec++; if (gate_state !== 3'd2) begin n_err++; $display("FAIL bp_state[%0d]: got %0d want 2", i, gate_state); end
      end
      n_vec++; if (dut.u_env.env !== 31'd10000) begin n_err++; $display("FAIL bp_env: got %0d want 10000", dut.u_env.env); end
      dout_tready = 1'b1;
      #1;
      n_vec++; if (din_tready !== 1'b1) begin n_err++; $display("FAIL bp_tready_release: got %b want 1", din_tready); end
      @(posedge clk);
      #1;
      n_vec++; if (dout !== 32'sd5555) begin n_err++; $display("FAIL bp_drain1: got %0d want 5555", dout); end
      din = 32'sd7777;
      @(posedge clk);
      #1;
      n_vec++; if (dout !== 32'sd7777) begin n_err++; $display("FAIL bp_drain2: got %0d want 7777", dout); end
      n_vec++; if (dout_tvalid !== 1'b1) begin n_err++; $display("FAIL bp_drain_tvalid: got %b want 1", dout_tvalid); end
      din_tvalid = 1'b0;
      @(posedge clk);
      #1;
      n_vec++; if (dout_tvalid !== 1'b0) begin n_err++; $display("FAIL bp_idle_tvalid: got %b want 0", dout_tvalid); end
   endtask

   task automatic test_most_negative();
      push(32'sh8000_0000);
      n_vec++; if (dout !== 32'sh8000_0000) begin n_err++; $display("FAIL minneg_dout: got %0d want -2147483648", dout); end
      n_vec++; if (dut.u_env.env !== 31'h7FFF_FFFF) begin n_err++; $display("FAIL minneg_env: got %0d want 2147483647", dut.u_env.env); end
      n_vec++; if (gate_state !== 3'd2) begin n_err++; $display("FAIL minneg_state: got %0d want 2", gate_state); end
   endtask

   task automatic test_reset_mid_attack();
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      n_vec++; if (din_tready !== 1'b1) begin n_err++; $display("FAIL rst2_tready: got %b want 1", din_tready); end
      push(32'sd10000);
      push(32'sd10000);
      n_vec++; if (dout !== 32'sd2500) begin n_err++; $display("FAIL rst2_pre_dout: got %0d want 2500", dout); end
      n_vec++; if (gate_state !== 3'd1) begin n_err++; $display("FAIL rst2_pre_state: got %0d want 1", gate_state); end
      din        = 32'sd10000;
      din_tvalid = 1'b1;
      rst_n      = 1'b0;
      @(posedge clk);
      #1;
      n_vec++; if (dout !== 32'sd0) begin n_err++; $display("FAIL rst2_dout: got %0d want 0", dout); end
      n_vec++; if (dout_tvalid !== 1'b0) begin n_err++; $display("FAIL rst2_tvalid: got %b want 0", dout_tvalid); end
      n_vec++; if (gate_state !== 3'd0) begin n_err++; $display("FAIL rst2_state: got %0d want 0", gate_state); end
      n_vec++; if (dut.gain !== 17'd0) begin n_err++; $display("FAIL rst2_gain: got %0d want 0", dut.gain); end
      n_vec++; if (dut.u_env.env !== 31'd0) begin n_err++; $display("FAIL rst2_env: got %0d want 0", dut.u_env.env); end
      din_tvalid = 1'b0;
      rst_n      = 1'b1;
      push(32'sd10000);
      n_vec++; if (dout !== 32'sd0) begin n_err++; $display("FAIL rst2_restart_dout: got %0d want 0", dout); end
      n_vec++; if (gate_state !== 3'd1) begin n_err++; $display("FAIL rst2_restart_state: got %0d want 1", gate_state); end
   endtask

   initial begin
      rst_n       = 1'b0;
      din         = '0;
      din_tvalid  = 1'b0;
      dout_tready = 1'b1;
      test_reset();
      test_closed_low_level();
      test_attack_step();
      test_release();
      test_reattack_from_release();
      test_backpressure();
      test_most_negative();
      test_reset_mid_attack();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
